mem_stage: RTL and testbench

//  Memory stage of the single-issue MIPS pipeline. Consumes the EX/MEM pipeline register driven by EXE.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/dmem_handshake.sv | 116 +++++++++++
 rtl/mem_stage.sv | 96 +++++++++
 tb/tb_mem_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared types and widths for the MIPS pipeline memory stage.
//                Holds the data-memory handshake state encoding and the
//                address, data and register-index widths.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ERROR = 2'd2
    } hs_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_handshake.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_handshake
//  Description : Data-memory req/ack sequencer for the MEM stage. Issues one
//                request per load/store, counts ack wait cycles, raises a
//                sticky error on misaligned access or timeout, and produces
//                the upstream freeze.
//  Ports       : CLK, RESET (async, active-low)
//                i_mem_read/i_mem_write/i_addr/i_wdata : EX/MEM access fields
//                i_ack                                 : memory completion
//                o_req/o_we/o_addr/o_wdata             : memory request bus
//                o_freeze                              : stall upstream
//                o_err                                 : sticky error
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_handshake
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_ack,
    output logic              o_req,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_freeze,
    output logic              o_err
);

    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

    hs_state_t        r_state;
    hs_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_access;
    logic             w_misalign;
    logic             w_req;
    logic             w_err;

    assign w_access   = i_mem_read | i_mem_write;
    assign w_misalign = (i_addr[1:0] != 2'b00);
    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_err      = (r_state == ST_ERROR);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The counter holds the number of cycles the request has waited so far;
    // the idle cycle that launched the request counts as the first.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_access) begin
                    if (w_misalign) begin
                        w_state_nxt = ST_ERROR;
                    end else begin
                        w_req = 1'b1;
                        if (!i_ack) begin
                            w_state_nxt = (TIMEOUT_CYCLES <= 1) ? ST_ERROR : ST_BUSY;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
            end
            ST_BUSY: begin
                w_req = 1'b1;
                if (i_ack) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_inc == c_TIMEOUT) begin
                    w_state_nxt = ST_ERROR;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_ERROR: begin
                w_state_nxt = ST_ERROR;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_req   = w_req;
    assign o_we    = i_mem_write;
    assign o_addr  = {i_addr[ADDR_W-1:2], 2'b00};
    assign o_wdata = i_wdata;
    assign o_err   = w_err;

    // Only an ack answering our own request releases the stall; a stray ack
    // alongside a misaligned access must not let upstream advance.
    assign o_freeze = w_err | (w_access & ~(i_ack & w_req));

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Memory stage of the single-issue MIPS pipeline. Consumes the
//                EX/MEM register, sequences data-memory loads/stores, owns
//                the MEM/WB register and drives forwarding buses to EXE.
//  Ports       : CLK, RESET (async, active-low)
//                *1_PR          : EX/MEM pipeline register fields
//                dmem_*         : data-memory req/ack bus
//                FREEZE         : stall IF/ID/EXE
//                *1_MEM, *1_WB  : forwarding / writeback buses
//                mem_err        : sticky misalign/timeout error
//  Revision    : 1.0  initial release
// ============================================================================
module mem_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] aluResult1_PR,
    input  logic [DATA_W-1:0] readDataB1_PR,
    input  logic [REG_W-1:0]  writeRegister1_PR,
    input  logic              do_writeback1_PR,
    input  logic              MemRead1_PR,
    input  logic              MemWrite1_PR,
    input  logic              MemtoReg1_PR,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              FREEZE,
    output logic [DATA_W-1:0] Data1_MEM,
    output logic [REG_W-1:0]  writeRegister1_MEM,
    output logic              do_writeback1_MEM,
    output logic [DATA_W-1:0] Data1_WB,
    output logic [REG_W-1:0]  writeRegister1_WB,
    output logic              do_writeback1_WB,
    output logic              mem_err
);

    logic [DATA_W-1:0] r_data_wb;
    logic [REG_W-1:0]  r_wreg_wb;
    logic              r_wb_wb;
    logic              w_freeze;

    dmem_handshake #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_hs (
        .CLK         (CLK),
        .RESET       (RESET),
        .i_mem_read  (MemRead1_PR),
        .i_mem_write (MemWrite1_PR),
        .i_addr      (aluResult1_PR),
        .i_wdata     (readDataB1_PR),
        .i_ack       (dmem_ack),
        .o_req       (dmem_req),
        .o_we        (dmem_we),
        .o_addr      (dmem_addr),
        .o_wdata     (dmem_wdata),
        .o_freeze    (w_freeze),
        .o_err       (mem_err)
    );

    // While frozen, push a bubble into WB but keep the data fields so the
    // last committed value stays visible on the WB forwarding bus.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_data_wb <= '0;
            r_wreg_wb <= '0;
            r_wb_wb   <= 1'b0;
        end else if (w_freeze) begin
            r_wb_wb   <= 1'b0;
        end else begin
            r_data_wb <= MemtoReg1_PR ? dmem_rdata : aluResult1_PR;
            r_wreg_wb <= writeRegister1_PR;
            r_wb_wb   <= do_writeback1_PR;
        end
    end

    assign FREEZE             = w_freeze;
    assign Data1_MEM          = aluResult1_PR;
    assign writeRegister1_MEM = writeRegister1_PR;
    // Load data is not available yet at MEM, so loads cannot forward here.
    assign do_writeback1_MEM  = do_writeback1_PR & ~MemRead1_PR;
    assign Data1_WB           = r_data_wb;
    assign writeRegister1_WB  = r_wreg_wb;
    assign do_writeback1_WB   = r_wb_wb;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage. Vector records carry the
//                EX/MEM inputs, memory response and expected combinational
//                outputs; a queue holds the predicted MEM/WB contents.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stage;

    logic        CLK;
    logic        RESET;
    logic [31:0] aluResult1_PR;
    logic [31:0] readDataB1_PR;
    logic [4:0]  writeRegister1_PR;
    logic        do_writeback1_PR;
    logic        MemRead1_PR;
    logic        MemWrite1_PR;
    logic        MemtoReg1_PR;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        FREEZE;
    logic [31:0] Data1_MEM;
    logic [4:0]  writeRegister1_MEM;
    logic        do_writeback1_MEM;
    logic [31:0] Data1_WB;
    logic [4:0]  writeRegister1_WB;
    logic        do_writeback1_WB;
    logic        mem_err;

    mem_stage #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (8)
    ) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .aluResult1_PR      (aluResult1_PR),
        .readDataB1_PR      (readDataB1_PR),
        .writeRegister1_PR  (writeRegister1_PR),
        .do_writeback1_PR   (do_writeback1_PR),
        .MemRead1_PR        (MemRead1_PR),
        .MemWrite1_PR       (MemWrite1_PR),
        .MemtoReg1_PR       (MemtoReg1_PR),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_ack           (dmem_ack),
        .dmem_rdata         (dmem_rdata),
        .FREEZE             (FREEZE),
        .Data1_MEM          (Data1_MEM),
        .writeRegister1_MEM (writeRegister1_MEM),
        .do_writeback1_MEM  (do_writeback1_MEM),
        .Data1_WB           (Data1_WB),
        .writeRegister1_WB  (writeRegister1_WB),
        .do_writeback1_WB   (do_writeback1_WB),
        .mem_err            (mem_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] datab;
        logic [4:0]  wreg;
        logic        wb;
        logic        mr;
        logic        mw;
        logic        mtr;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_we;
        logic        e_frz;
        logic        e_err;
        logic        e_fwb;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  r;
        logic        w;
    } wb_t;

    int          n_pass;
    int          n_tot;
    wb_t         sb[$];
    logic [31:0] m_data;
    logic [4:0]  m_reg;
    logic        m_wb;
    vec_t        tbl[6];

    function automatic vec_t mk(input logic [31:0] alu, input logic [31:0] datab,
                                input logic [4:0] wreg, input logic wb,
                                input logic mr, input logic mw, input logic mtr,
                                input logic ack, input logic [31:0] rdata,
                                input logic e_req, input logic e_we, input logic e_frz,
                                input logic e_err, input logic e_fwb);
        vec_t v;
        v.alu = alu;   v.datab = datab; v.wreg = wreg; v.wb = wb;
        v.mr = mr;     v.mw = mw;       v.mtr = mtr;   v.ack = ack;
        v.rdata = rdata;
        v.e_req = e_req; v.e_we = e_we; v.e_frz = e_frz;
        v.e_err = e_err; v.e_fwb = e_fwb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Called just after a rising edge: drive, check combinational outputs
    // mid-cycle, predict MEM/WB, then check it just after the next edge.
    task automatic run_cycle(input vec_t v);
        wb_t e;
        aluResult1_PR     = v.alu;
        readDataB1_PR     = v.datab;
        writeRegister1_PR = v.wreg;
        do_writeback1_PR  = v.wb;
        MemRead1_PR       = v.mr;
        MemWrite1_PR      = v.mw;
        MemtoReg1_PR      = v.mtr;
        dmem_ack          = v.ack;
        dmem_rdata        = v.rdata;
        @(negedge CLK);
        chk("dmem_req", dmem_req, v.e_req);
        chk("FREEZE", FREEZE, v.e_frz);
        chk("mem_err", mem_err, v.e_err);
        chk("do_writeback1_MEM", do_writeback1_MEM, v.e_fwb);
        chk("Data1_MEM", Data1_MEM, v.alu);
        chk("writeRegister1_MEM", writeRegister1_MEM, v.wreg);
        if (v.e_req) begin
            chk("dmem_addr", dmem_addr, {v.alu[31:2], 2'b00});
            chk("dmem_we", dmem_we, v.e_we);
            if (v.e_we) chk("dmem_wdata", dmem_wdata, v.datab);
        end
        if (v.e_frz) begin
            m_wb = 1'b0;
        end else begin
            m_data = v.mtr ? v.rdata : v.alu;
            m_reg  = v.wreg;
            m_wb   = v.wb;
        end
        sb.push_back('{m_data, m_reg, m_wb});
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        chk("Data1_WB", Data1_WB, e.d);
        chk("writeRegister1_WB", writeRegister1_WB, e.r);
        chk("do_writeback1_WB", do_writeback1_WB, e.w);
    endtask

    // Asynchronous reset pulse taken between edges, with idle inputs.
    task automatic do_reset();
        aluResult1_PR = '0; readDataB1_PR = '0; writeRegister1_PR = '0;
        do_writeback1_PR = 1'b0; MemRead1_PR = 1'b0; MemWrite1_PR = 1'b0;
        MemtoReg1_PR = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
        RESET = 1'b0;
        #2;
        chk("rst Data1_WB", Data1_WB, 32'h0);
        chk("rst writeRegister1_WB", writeRegister1_WB, 32'h0);
        chk("rst do_writeback1_WB", do_writeback1_WB, 32'h0);
        chk("rst mem_err", mem_err, 32'h0);
        chk("rst FREEZE", FREEZE, 32'h0);
        chk("rst dmem_req", dmem_req, 32'h0);
        m_data = '0; m_reg = '0; m_wb = 1'b0;
        sb.delete();
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass = 0;
        n_tot  = 0;
        RESET  = 1'b0;
        aluResult1_PR = '0; readDataB1_PR = '0; writeRegister1_PR = '0;
        do_writeback1_PR = 1'b0; MemRead1_PR = 1'b0; MemWrite1_PR = 1'b0;
        MemtoReg1_PR = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
        m_data = '0; m_reg = '0; m_wb = 1'b0;

        //           alu           datab         wr  wb mr mw mtr ack rdata         req we frz err fwb
        tbl[0] = mk(32'h0000_1234, 32'h0,        5,  1, 0, 0, 0,  0,  32'h0,        0,  0, 0,  0,  1);
        tbl[1] = mk(32'h0000_0200, 32'hA5A5A5A5, 0,  0, 0, 1, 0,  1,  32'h0,        1,  1, 0,  0,  0);
        tbl[2] = mk(32'h0000_0104, 32'h0,        7,  1, 1, 0, 1,  1,  32'hCAFEF00D, 1,  0, 0,  0,  0);
        tbl[3] = mk(32'h0000_0055, 32'h0,        3,  1, 0, 0, 0,  1,  32'hFFFF0000, 0,  0, 0,  0,  1);
        tbl[4] = mk(32'h0000_0301, 32'h11223344, 0,  0, 1, 1, 0,  1,  32'h0,        0,  0, 1,  0,  0);
        tbl[5] = mk(32'h0000_ABCD, 32'h0,        9,  0, 0, 0, 0,  0,  32'h0,        0,  0, 0,  0,  0);
        // Read+write together is a store; aligned variant of tbl[4].
        tbl[4] = mk(32'h0000_0300, 32'h11223344, 0,  0, 1, 1, 0,  1,  32'h0,        1,  1, 0,  0,  0);

        repeat (2) @(posedge CLK);
        #1;
        do_reset();

        foreach (tbl[i]) run_cycle(tbl[i]);

        // Load from 0x100 with three wait cycles, then ALU op forwarding.
        for (int k = 0; k < 3; k++)
            run_cycle(mk(32'h100, 32'h0, 7, 1, 1, 0, 1, 0, 32'h0, 1, 0, 1, 0, 0));
        run_cycle(mk(32'h100, 32'h0, 7, 1, 1, 0, 1, 1, 32'hDEADBEEF, 1, 0, 0, 0, 0));
        run_cycle(mk(32'h1234, 32'h0, 5, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 1));

        // Misaligned load: no request, error is sticky until reset.
        run_cycle(mk(32'h103, 32'h0, 7, 1, 1, 0, 1, 0, 32'h0, 0, 0, 1, 0, 0));
        run_cycle(mk(32'h103, 32'h0, 7, 1, 1, 0, 1, 0, 32'h0, 0, 0, 1, 1, 0));
        run_cycle(mk(32'h1, 32'h0, 2, 1, 0, 0, 0, 0, 32'h0, 0, 0, 1, 1, 1));
        do_reset();

        // Timeout: four waited cycles with request, then error.
        for (int k = 0; k < 4; k++)
            run_cycle(mk(32'h400, 32'h0, 4, 1, 1, 0, 1, 0, 32'h0, 1, 0, 1, 0, 0));
        run_cycle(mk(32'h400, 32'h0, 4, 1, 1, 0, 1, 0, 32'h0, 0, 0, 1, 1, 0));
        run_cycle(mk(32'h400, 32'h0, 4, 1, 1, 0, 1, 1, 32'h77, 0, 0, 1, 1, 0));
        do_reset();

        // Back to normal operation after reset.
        run_cycle(mk(32'h0000_0208, 32'h0BADCAFE, 0, 0, 0, 1, 0, 1, 32'h0, 1, 1, 0, 0, 0));
        run_cycle(mk(32'h0000_0042, 32'h0, 12, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 1));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
